// File: rtl/avl_bus_type.sv
// Avalon bus types: the downstream command word and the arbitration method enum.
`ifndef ALV_BURST_MAX_COUNT
`include "avl_bus_define.sv"
`endif

package avl_bus_type;

    typedef enum logic [1:0] {
        ARB_RR    = 2'd0,
        ARB_FIXED = 2'd1,
        ARB_WRR   = 2'd2
    } arb_method_e;

    typedef struct packed {
        logic                               read;
        logic                               write;
        logic                               begin_burst_transfer;
        logic [`ALV_BURST_MAX_COUNT-1:0]    burst_count;
    } avl_cmd_t;

endpackage

// File: rtl/avl_bus_define.sv
// Global Avalon bus widths shared by the bus type package and every bus block.
`ifndef ALV_BURST_MAX_COUNT
`define ALV_BURST_MAX_COUNT 8
`endif

// File: rtl/avl_bus_priority_encoder.sv
// Lowest-index-wins priority encoder; found is low when no input bit is set.
module avl_bus_priority_encoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         req,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     found
);
    localparam int IDX_W = $clog2(WIDTH);

    always_comb begin
        // NOTE: outputs get defaults before the loop so every path assigns them and no latch is inferred.
        idx   = '0;
        found = 1'b0;
        // NOTE: blocking assignments: each lower index overwrites the previous hit, so the lowest set bit wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avl_bus_n21_wrr_arb.sv
// N-to-1 Avalon arbiter: round-robin, fixed priority with anti-starvation, or weighted
// round-robin, with the grant frozen during a pending command or a write burst.
module avl_bus_n21_wrr_arb
    import avl_bus_type::*;
#(
    parameter int ARB_METHOD   = 0,
    parameter int MASTER_NUM   = 8,
    parameter int WEIGHT_WIDTH = 4,
    parameter int MAX_WAIT     = 64
) (
    input  logic                               clk,
    input  logic                               rest,
    input  logic [MASTER_NUM-1:0]              request,
    input  logic [MASTER_NUM*WEIGHT_WIDTH-1:0] weights,
    input  avl_cmd_t                           avl_out_cmd,
    input  logic                               avl_out_request_ready,
    output logic [$clog2(MASTER_NUM)-1:0]      sel,
    output logic [MASTER_NUM-1:0]              grant,
    output logic                               grant_valid,
    output logic                               locked
);
    localparam int SEL_W = $clog2(MASTER_NUM);
    localparam int BC_W  = `ALV_BURST_MAX_COUNT;
    localparam bit MODE_FIXED = (ARB_METHOD == int'(ARB_FIXED));
    localparam bit MODE_WRR   = (ARB_METHOD == int'(ARB_WRR));
    localparam logic [SEL_W:0] N_EXT   = (SEL_W + 1)'(MASTER_NUM);
    localparam logic [7:0]     WAIT_SAT = 8'(MAX_WAIT);

    generate
        if (ARB_METHOD != int'(ARB_RR) && !MODE_FIXED && !MODE_WRR) begin : g_bad_method
            $error("avl_bus_n21_wrr_arb: ARB_METHOD must be 0, 1 or 2");
        end
        if (MASTER_NUM < 2 || MASTER_NUM > 16) begin : g_bad_master_num
            $error("avl_bus_n21_wrr_arb: MASTER_NUM must be in 2..16");
        end
        if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
            $error("avl_bus_n21_wrr_arb: MAX_WAIT must be in 1..255");
        end
    endgenerate

    logic [SEL_W-1:0]        sel_q;
    logic [SEL_W-1:0]        last_sel;
    logic [BC_W-1:0]         beats_left;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic [7:0]              wait_cnt [MASTER_NUM];
    logic                    pend_q;

    logic cmd_valid, accept, burst_lock, wrr_lock;

    assign cmd_valid  = avl_out_cmd.read | avl_out_cmd.write;
    assign accept     = avl_out_request_ready & cmd_valid;
    assign burst_lock = (beats_left != '0);
    assign wrr_lock   = MODE_WRR && (credit != '0) && request[sel_q];
    assign locked     = pend_q | burst_lock | wrr_lock;

    // Rotate/mask stage feeding the shared encoder; offset maps its index back to a master.
    logic [SEL_W-1:0]        start, offset, enc_idx, winner;
    logic [2*MASTER_NUM-1:0] req_dbl;
    logic [MASTER_NUM-1:0]   starved, enc_in;
    logic [SEL_W:0]          sum, diff;
    logic                    enc_found;

    always_comb begin
        start   = (last_sel == SEL_W'(MASTER_NUM - 1)) ? '0 : last_sel + SEL_W'(1);
        starved = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            starved[i] = request[i] && (wait_cnt[i] == WAIT_SAT);
        end
        req_dbl = {request, request} >> start;
        if (MODE_FIXED) begin
            enc_in = (starved != '0) ? starved : request;
            offset = '0;
        end else begin
            enc_in = req_dbl[MASTER_NUM-1:0];
            offset = start;
        end
    end

    avl_bus_priority_encoder #(
        .WIDTH (MASTER_NUM)
    ) u_enc (
        .req   (enc_in),
        .idx   (enc_idx),
        .found (enc_found)
    );

    always_comb begin
        sum    = {1'b0, offset} + {1'b0, enc_idx};
        diff   = sum - N_EXT;
        winner = (sum >= N_EXT) ? diff[SEL_W-1:0] : sum[SEL_W-1:0];
        sel    = (locked || !enc_found) ? sel_q : winner;
        grant_valid = locked | enc_found;
        grant  = '0;
        if (grant_valid) begin
            grant[sel] = 1'b1;
        end
    end

    logic [WEIGHT_WIDTH-1:0] w_sel, credit_load;

    // Credit counts grants remaining after the current one, so a weight of 1 never holds.
    always_comb begin
        w_sel       = weights[sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        credit_load = (w_sel == '0) ? '0 : w_sel - WEIGHT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            sel_q      <= '0;
            last_sel   <= SEL_W'(MASTER_NUM - 1);
            beats_left <= '0;
            credit     <= '0;
            pend_q     <= 1'b0;
            // NOTE: wait_cnt is a small flop array, not a RAM, so it is cleared with the rest of the state.
            for (int i = 0; i < MASTER_NUM; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            sel_q <= sel;
            if (accept) begin
                last_sel <= sel;
            end
            if (cmd_valid) begin
                pend_q <= !avl_out_request_ready;
            end

            if (accept && avl_out_cmd.write) begin
                if (burst_lock) begin
                    beats_left <= beats_left - BC_W'(1);
                end else if (avl_out_cmd.begin_burst_transfer && avl_out_cmd.burst_count > BC_W'(1)) begin
                    beats_left <= avl_out_cmd.burst_count - BC_W'(1);
                end
            end

            if (!wrr_lock) begin
                credit <= (MODE_WRR && accept && !locked) ? credit_load : '0;
            end else if (accept) begin
                credit <= credit - WEIGHT_WIDTH'(1);
            end

            for (int i = 0; i < MASTER_NUM; i++) begin
                if (!request[i] || (accept && sel == SEL_W'(i))) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != WAIT_SAT) begin
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_avl_bus_n21_wrr_arb.sv
// Directed bench: one arbiter per method, all driven from the same bus stimulus.
module tb_avl_bus_n21_wrr_arb;
    import avl_bus_type::*;

    logic        clk = 1'b0;
    logic        rest;
    logic [7:0]  request;
    logic [31:0] weights;
    avl_cmd_t    cmd;
    logic        ready;

    logic [2:0] sel_rr, sel_fp, sel_wrr;
    logic [7:0] grant_rr, grant_fp, grant_wrr;
    logic       gv_rr, gv_fp, gv_wrr;
    logic       lk_rr, lk_fp, lk_wrr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    avl_bus_n21_wrr_arb #(.ARB_METHOD(0), .MASTER_NUM(8), .WEIGHT_WIDTH(4), .MAX_WAIT(64)) u_rr (
        .clk(clk), .rest(rest), .request(request), .weights(weights),
        .avl_out_cmd(cmd), .avl_out_request_ready(ready),
        .sel(sel_rr), .grant(grant_rr), .grant_valid(gv_rr), .locked(lk_rr)
    );

    avl_bus_n21_wrr_arb #(.ARB_METHOD(1), .MASTER_NUM(8), .WEIGHT_WIDTH(4), .MAX_WAIT(4)) u_fp (
        .clk(clk), .rest(rest), .request(request), .weights(weights),
        .avl_out_cmd(cmd), .avl_out_request_ready(ready),
        .sel(sel_fp), .grant(grant_fp), .grant_valid(gv_fp), .locked(lk_fp)
    );

    avl_bus_n21_wrr_arb #(.ARB_METHOD(2), .MASTER_NUM(8), .WEIGHT_WIDTH(4), .MAX_WAIT(64)) u_wrr (
        .clk(clk), .rest(rest), .request(request), .weights(weights),
        .avl_out_cmd(cmd), .avl_out_request_ready(ready),
        .sel(sel_wrr), .grant(grant_wrr), .grant_valid(gv_wrr), .locked(lk_wrr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus away from the rising edge, then let outputs settle.
    task automatic drive(input logic [7:0] req, input logic rd, input logic wr, input logic bb,
                         input logic [`ALV_BURST_MAX_COUNT-1:0] bc, input logic rdy);
        @(negedge clk);
        request                  = req;
        cmd                      = '0;
        cmd.read                 = rd;
        cmd.write                = wr;
        cmd.begin_burst_transfer = bb;
        cmd.burst_count          = bc;
        ready                    = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rest    = 1'b1;
        request = '0;
        cmd     = '0;
        ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rest = 1'b0;
        #1;
    endtask

    initial begin
        int exp_fp  [6] = '{0, 0, 0, 0, 7, 0};
        int exp_wrr [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        int exp_wlk [8] = '{0, 1, 1, 0, 0, 1, 1, 0};

        rest    = 1'b1;
        request = '0;
        cmd     = '0;
        ready   = 1'b0;
        weights = 32'h0000_0013;

        // Reset state with no requests
        do_reset();
        check("rst_sel", sel_rr, 0);
        check("rst_grant", grant_rr, 0);
        check("rst_gv", gv_rr, 0);
        check("rst_locked", lk_rr, 0);

        // A read with begin_burst is a single command
        drive(8'hFF, 1, 0, 1, 4, 1);
        check("rdburst_sel", sel_rr, 0);
        drive(8'hFF, 1, 0, 0, 1, 1);
        check("rdburst_next_sel", sel_rr, 1);
        check("rdburst_next_lk", lk_rr, 0);

        // Round-robin sweep
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(8'hFF, 0, 1, 0, 1, 1);
            check($sformatf("rr_seq%0d_sel", k), sel_rr, k % 8);
            check($sformatf("rr_seq%0d_grant", k), grant_rr, 32'(1) << (k % 8));
        end

        // Master 2 write burst of 4 beats
        do_reset();
        drive(8'hFF, 0, 1, 0, 1, 1);
        drive(8'hFF, 0, 1, 0, 1, 1);
        drive(8'hFF, 0, 1, 1, 4, 1);
        check("burst_first_sel", sel_rr, 2);
        check("burst_first_lk", lk_rr, 0);
        for (int k = 0; k < 3; k++) begin
            drive(8'hFF, 0, 1, 0, 1, 1);
            check($sformatf("burst_beat%0d_sel", k + 2), sel_rr, 2);
            check($sformatf("burst_beat%0d_lk", k + 2), lk_rr, 1);
        end
        drive(8'hFF, 0, 1, 0, 1, 1);
        check("burst_after_sel", sel_rr, 3);
        check("burst_after_lk", lk_rr, 0);

        // No request: outputs idle, sel held
        drive(8'h00, 0, 0, 0, 1, 1);
        check("idle_sel_held", sel_rr, 3);
        check("idle_grant", grant_rr, 0);
        check("idle_gv", gv_rr, 0);

        // Pending lock while ready is low and requests change
        do_reset();
        drive(8'hFF, 0, 1, 0, 1, 1);
        drive(8'hFF, 0, 1, 0, 1, 0);
        check("pend_start_sel", sel_rr, 1);
        for (int k = 0; k < 2; k++) begin
            drive(8'h01, 0, 1, 0, 1, 0);
            check($sformatf("pend_hold%0d_sel", k), sel_rr, 1);
            check($sformatf("pend_hold%0d_lk", k), lk_rr, 1);
            check($sformatf("pend_hold%0d_grant", k), grant_rr, 8'h02);
        end
        drive(8'h01, 0, 1, 0, 1, 1);
        check("pend_accept_sel", sel_rr, 1);
        drive(8'h01, 0, 0, 0, 1, 1);
        check("pend_release_sel", sel_rr, 0);
        check("pend_release_lk", lk_rr, 0);

        // Fixed priority with starvation threshold 4
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(8'h81, 0, 1, 0, 1, 1);
            check($sformatf("fp_cyc%0d_sel", k + 1), sel_fp, exp_fp[k]);
        end

        // Weighted round-robin, w0=3 w1=1
        weights = 32'h0000_0013;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(8'h03, 0, 1, 0, 1, 1);
            check($sformatf("wrr_cyc%0d_sel", k), sel_wrr, exp_wrr[k]);
            check($sformatf("wrr_cyc%0d_lk", k), lk_wrr, exp_wlk[k]);
        end

        // Weight 0 behaves as weight 1: plain alternation, never locked
        weights = 32'h0000_0010;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(8'h03, 0, 1, 0, 1, 1);
            check($sformatf("wrr_w0_cyc%0d_sel", k), sel_wrr, k % 2);
            check($sformatf("wrr_w0_cyc%0d_lk", k), lk_wrr, 0);
        end

        // Reset pulsed after two beats of a master-2 burst
        do_reset();
        drive(8'hFF, 0, 1, 0, 1, 1);
        drive(8'hFF, 0, 1, 0, 1, 1);
        drive(8'hFF, 0, 1, 1, 4, 1);
        drive(8'hFF, 0, 1, 0, 1, 1);
        check("rstburst_pre_lk", lk_rr, 1);
        @(negedge clk);
        rest    = 1'b1;
        request = 8'hFF;
        cmd     = '0;
        @(negedge clk);
        rest = 1'b0;
        #1;
        check("rstburst_lk", lk_rr, 0);
        check("rstburst_sel", sel_rr, 0);
        check("rstburst_gv", gv_rr, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
